// File: rtl/imem_loader.sv
// Byte-stream to imem loader: packs bytes into 32-bit words, writes them at word addresses 0..N-1.
// Latency: we pulses the cycle after the 4th byte of a word; byte_ready is low during WRITE/IDLE/DONE.
// Optional trailing checksum word compared to the sum of written words: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W     = 6,
    parameter bit LITTLE_END = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_words,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              we,
    output logic [ADDR_W-1:0] wa,
    output logic [31:0]       wd,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK   = 3'd3,
`endif
        S_DONE    = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] ONE = 1;

    state_t          state, state_nxt;
    logic [1:0]      byte_cnt;
    logic [1:0]      lane;
    logic [ADDR_W:0] word_cnt, word_tgt;
    logic [31:0]     asm_word, asm_nxt;
    logic            start_ok, accept, last_byte, last_word;

    assign start_ok  = start && (state == S_IDLE || state == S_DONE);
    assign accept    = byte_valid && byte_ready;
    assign last_byte = accept && (byte_cnt == 2'd3);
    assign last_word = (word_cnt + ONE) == word_tgt;
    assign lane      = LITTLE_END ? byte_cnt : ~byte_cnt;

    always_comb begin
        asm_nxt = asm_word;
        asm_nxt[{lane, 3'b000} +: 8] = byte_in;
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_COLLECT;
            S_COLLECT:      if (last_byte) state_nxt = S_WRITE;
            S_WRITE: begin
                if (!last_word)
                    state_nxt = S_COLLECT;
                else
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_nxt = S_CHECK;
`else
                    state_nxt = S_DONE;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK:        if (last_byte) state_nxt = S_DONE;
`endif
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        we         = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_COLLECT: begin byte_ready = 1'b1; busy = 1'b1; end
            S_WRITE:   begin we = 1'b1;         busy = 1'b1; end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK:   begin byte_ready = 1'b1; busy = 1'b1; end
`endif
            S_DONE:    done = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            byte_cnt <= '0;
            word_cnt <= '0;
            word_tgt <= '0;
            asm_word <= '0;
            wa       <= '0;
            wd       <= '0;
        end else begin
            if (start_ok) begin
                word_tgt <= (num_words == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, num_words};
                word_cnt <= '0;
                byte_cnt <= '0;
                wa       <= '0;
            end
            if (accept) begin
                asm_word <= asm_nxt;
                byte_cnt <= byte_cnt + 2'd1;
                // wd only moves on a completed data word, never for the checksum word
                if (byte_cnt == 2'd3 && state == S_COLLECT)
                    wd <= asm_nxt;
            end
            if (state == S_WRITE) begin
                word_cnt <= word_cnt + ONE;
                if (!last_word)
                    wa <= wa + 1'b1;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] sum;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sum <= '0;
            err <= 1'b0;
        end else begin
            if (start_ok) begin
                sum <= '0;
                err <= 1'b0;
            end
            if (state == S_WRITE)
                sum <= sum + wd;
            if (state == S_CHECK && last_byte)
                err <= (asm_nxt != sum);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the instruction memory: receives a byte stream and assembles 32-bit instruction words.
- Writes each word into imem at consecutive word addresses starting at 0.
- Sits between a host/byte source (UART receiver or testbench) and the imem write port. Loads the program before the pipeline is released from reset.

Parameters:
ADDR_W, 6, imem word-address width (depth = 2**ADDR_W words)
LITTLE_END, 1, 1 = first received byte is wd[7:0]; 0 = first received byte is wd[31:24]

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
start  input  1  one-cycle request to begin a load; sampled only in IDLE or DONE
num_words  input  ADDR_W  words to load, latched on accepted start; 0 means 2**ADDR_W
byte_in  input  8  stream data
byte_valid  input  1  byte_in is valid
byte_ready  output  1  loader accepts a byte this cycle
we  output  1  imem write enable, one-cycle pulse per word
wa  output  ADDR_W  imem word write address
wd  output  32  imem write data
busy  output  1  load in progress
done  output  1  load complete, held until next accepted start or reset
err  output  1  checksum mismatch, valid when done=1

Behaviour:
- Reset (reset==0 at a clock edge) forces state IDLE and clears all outputs and internal registers: byte_ready=0, we=0, wa=0, wd=0, busy=0, done=0, err=0, byte counter=0, word counter=0. Reset mid-load abandons the load; no further writes occur.
- States: IDLE, COLLECT, WRITE, CHECK (feature only), DONE.
- IDLE/DONE, start=1: latch num_words, clear wa, word counter, byte counter, err and done; set busy=1; go to COLLECT. start is ignored in COLLECT, WRITE and CHECK.
- COLLECT: byte_ready=1. A byte is accepted when byte_valid && byte_ready. It is placed in lane byte_cnt (LITTLE_END=1) or lane 3-byte_cnt (LITTLE_END=0), and byte_cnt is incremented mod 4.
- On the edge that accepts the 4th byte, go to WRITE. wd holds the assembled word.
- WRITE: exactly one cycle. we=1, wa = current word index, byte_ready=0.
  - Latency: 4th byte accepted at edge N; we is high in the cycle after edge N.
  - Leaving WRITE, the word counter increments. If it equals the effective count (num_words, or 2**ADDR_W if 0), go to DONE (or CHECK with the feature). Otherwise wa increments and the state returns to COLLECT.
- wa never wraps during a load. With num_words=0, the last write is at address 2**ADDR_W-1.
- DONE: busy=0, done=1, byte_ready=0, we=0. Bytes presented in DONE are not consumed.
- byte_valid may drop at any time. Partial words wait indefinitely; there is no timeout.
- we is never high outside WRITE. wd and wa hold their values between writes.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running 32-bit sum (mod 2**32) of all written words is kept; it is cleared on accepted start.
  - After the last WRITE, go to CHECK. Collect one further 4-byte word with the same byte order and handshake, but do not write it (we stays 0).
  - On its 4th byte, set err = (word != sum) and go to DONE.
- Undefined: CHECK state and sum logic are absent, err is tied to 0, and WRITE goes directly to DONE.

Test Plan:
- Reset: hold reset=0 for 3 cycles with byte_valid=1 -> all outputs 0, byte_ready=0, no we.
- Basic load: LITTLE_END=1, start with num_words=2, bytes 13 00 08 20 8C 44 00 04 -> we pulses at wa=0 wd=0x20080013, then wa=1 wd=0x0400448C. Then done=1, busy=0, err=0. Each we occurs one cycle after its 4th byte.
- Stalls and big-endian: LITTLE_END=0, byte_valid toggled 1/0 every cycle, bytes 20 08 00 13 -> single write wd=0x20080013 at wa=0. byte_ready=0 in the WRITE cycle.
- Full depth: num_words=0, 256 bytes -> 64 writes with wa 0..63 in order, then done=1. Extra bytes are not accepted (byte_ready=0).
- Mid-load reset and restart: reset after 6 bytes -> idle with no second write. A new start with num_words=1 writes its word at wa=0.
- Checksum (IMEM_LOADER_CHECKSUM_EN): words 0x00000001, 0x00000002, then checksum 0x00000003 -> err=0. Repeat with checksum 0x00000004 -> err=1. Exactly 2 we pulses in each case.
